// File: rtl/opcode_tag_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : opcode_tag_allocator_pkg
// Brief   : Shared opcode types, tag type and per-type tag base constants
//           for the opcode tag allocator and its users.
// Revision: 1.0 - initial release
// ============================================================================
package opcode_tag_allocator_pkg;

  localparam int OPCODE_NUM_TYPES     = 5;
  localparam int OPCODE_TAG_IDX_W     = 6;
  localparam int OPCODE_TAGS_PER_TYPE = 1 << OPCODE_TAG_IDX_W;
  localparam int OPCODE_TAG_W         = 9;

  typedef enum logic [2:0] {
    OPCODE_READ  = 3'd0,
    OPCODE_WRITE = 3'd1,
    OPCODE_WAIT  = 3'd2,
    OPCODE_EVICT = 3'd3,
    OPCODE_TRIM  = 3'd4
  } opcodeEnumT;

  typedef logic [OPCODE_TAG_W-1:0] opcodeTagT;

  // Base tag of each pool: type * TAGS_PER_TYPE.
  localparam opcodeTagT OPCODEABASE_READ  = 9'h000;
  localparam opcodeTagT OPCODEABASE_WRITE = 9'h040;
  localparam opcodeTagT OPCODEABASE_WAIT  = 9'h080;
  localparam opcodeTagT OPCODEABASE_EVICT = 9'h0C0;
  localparam opcodeTagT OPCODEABASE_TRIM  = 9'h100;

  // Base tag for an opcode type, matching the constants above.
  function automatic opcodeTagT opcode_tag_base(input opcodeEnumT op);
    return opcodeTagT'(op) << OPCODE_TAG_IDX_W;
  endfunction

endpackage : opcode_tag_allocator_pkg
`default_nettype wire

// File: rtl/opcode_tag_allocator_if.sv
`default_nettype none
// ============================================================================
// Module  : opcode_tag_allocator_if
// Brief   : Request / response / release bus between the command front-end
//           (master) and the opcode tag allocator (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface opcode_tag_allocator_if
  import opcode_tag_allocator_pkg::*;
#(
  parameter int TYPE_W = $clog2(OPCODE_NUM_TYPES),
  parameter int TAG_W  = OPCODE_TAG_W
);

  logic              alloc_valid;
  logic [TYPE_W-1:0] alloc_type;
  logic              alloc_ready;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_ready;
  logic              rel_valid;
  logic [TAG_W-1:0]  rel_tag;

  modport master (
    output alloc_valid, alloc_type, rsp_ready, rel_valid, rel_tag,
    input  alloc_ready, rsp_valid, rsp_tag
  );

  modport slave (
    input  alloc_valid, alloc_type, rsp_ready, rel_valid, rel_tag,
    output alloc_ready, rsp_valid, rsp_tag
  );

endinterface : opcode_tag_allocator_if
`default_nettype wire

// File: rtl/opcode_tag_pool.sv
`default_nettype none
// ============================================================================
// Module  : opcode_tag_pool
// Brief   : One opcode type's tag pool: allocation bitmap, lowest-free
//           priority encoder, occupancy count and full flag.
// Revision: 1.0 - initial release
// ============================================================================
module opcode_tag_pool
  import opcode_tag_allocator_pkg::*;
#(
  parameter int TAGS_PER_TYPE = OPCODE_TAGS_PER_TYPE,
  parameter int IDX_W         = $clog2(TAGS_PER_TYPE),
  parameter int CNT_W         = $clog2(TAGS_PER_TYPE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_en,    // caller guarantees pool not full
  output logic [IDX_W-1:0] alloc_idx,   // lowest free index, pre-release view
  input  logic             rel_en,
  input  logic [IDX_W-1:0] rel_idx,
  output logic             dbl_free,    // rel_en on an index that is free
  output logic [CNT_W-1:0] in_use_cnt,
  output logic             pool_full
);

  logic [TAGS_PER_TYPE-1:0] r_bitmap;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_full;

  logic                     w_rel_hit;
  logic [TAGS_PER_TYPE-1:0] w_set_mask;
  logic [TAGS_PER_TYPE-1:0] w_clr_mask;
  logic [CNT_W-1:0]         w_cnt_next;

  // Priority encoder: scanning downward leaves the lowest free index last.
  always_comb begin
    alloc_idx = '0;
    for (int i = TAGS_PER_TYPE - 1; i >= 0; i--) begin
      if (!r_bitmap[i]) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign w_rel_hit  = rel_en &  r_bitmap[rel_idx];
  assign dbl_free   = rel_en & ~r_bitmap[rel_idx];
  assign w_set_mask = alloc_en  ? (TAGS_PER_TYPE'(1) << alloc_idx) : '0;
  assign w_clr_mask = w_rel_hit ? (TAGS_PER_TYPE'(1) << rel_idx)   : '0;
  assign w_cnt_next = r_cnt + CNT_W'(alloc_en) - CNT_W'(w_rel_hit);

  // Bitmap, count and full flag advance together; flush empties the pool.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitmap <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
    end else if (flush) begin
      r_bitmap <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
    end else begin
      r_bitmap <= (r_bitmap | w_set_mask) & ~w_clr_mask;
      r_cnt    <= w_cnt_next;
      r_full   <= (w_cnt_next == CNT_W'(TAGS_PER_TYPE));
    end
  end

  assign in_use_cnt = r_cnt;
  assign pool_full  = r_full;

endmodule : opcode_tag_pool
`default_nettype wire

// File: rtl/opcode_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module  : opcode_tag_allocator
// Brief   : Hands out unique tags (type*TAGS_PER_TYPE + index) from per-type
//           pools, reclaims them on release, tracks occupancy, supports
//           flush and flags illegal types and double frees.
// Revision: 1.0 - initial release
// ============================================================================
module opcode_tag_allocator
  import opcode_tag_allocator_pkg::*;
#(
  parameter int  NUM_TYPES     = OPCODE_NUM_TYPES,
  parameter int  TAGS_PER_TYPE = OPCODE_TAGS_PER_TYPE,
  parameter int  TAG_W         = OPCODE_TAG_W,
  localparam int IDX_W         = $clog2(TAGS_PER_TYPE),
  localparam int TYPE_W        = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1,
  localparam int CNT_W         = $clog2(TAGS_PER_TYPE + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  opcode_tag_allocator_if.slave      bus,
  input  logic                       flush,
  output logic [NUM_TYPES*CNT_W-1:0] in_use_cnt,
  output logic [NUM_TYPES-1:0]       pool_full,
  output logic                       err_illegal,
  output logic                       err_double_free
);

  if (TAG_W < $clog2(NUM_TYPES * TAGS_PER_TYPE)) begin : g_chk_tag_w
    $error("opcode_tag_allocator: TAG_W too narrow for NUM_TYPES*TAGS_PER_TYPE");
  end
  if ((TAGS_PER_TYPE < 2) || ((TAGS_PER_TYPE & (TAGS_PER_TYPE - 1)) != 0)) begin : g_chk_depth
    $error("opcode_tag_allocator: TAGS_PER_TYPE must be a power of two >= 2");
  end

  logic                    w_alloc_legal;
  logic                    w_alloc_ready;
  logic                    w_sel_full;
  logic [IDX_W-1:0]        w_sel_idx;
  logic                    w_xfer;
  logic                    w_alloc_bad;
  logic [TYPE_W-1:0]       w_rel_type;
  logic [IDX_W-1:0]        w_rel_idx;
  logic                    w_rel_legal;
  logic                    w_rel_bad;
  logic [NUM_TYPES-1:0]    w_alloc_en;
  logic [NUM_TYPES-1:0]    w_rel_en;
  logic [NUM_TYPES-1:0]    w_dbl_free;
  logic [IDX_W-1:0]        w_alloc_idx [NUM_TYPES];

  logic                    r_rsp_valid;
  logic [TAG_W-1:0]        r_rsp_tag;
  logic                    r_err_illegal;
  logic                    r_err_double_free;

  assign w_alloc_legal = (int'(bus.alloc_type) < NUM_TYPES);

  // Route the requested pool's full flag and lowest-free index.
  always_comb begin
    w_sel_full = 1'b0;
    w_sel_idx  = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (bus.alloc_type == TYPE_W'(t)) begin
        w_sel_full = pool_full[t];
        w_sel_idx  = w_alloc_idx[t];
      end
    end
  end

  // Ready depends only on state and type: illegal types are swallowed,
  // legal ones need room in the pool and in the response register.
  always_comb begin
    w_alloc_ready = 1'b0;
    if (flush) begin
      w_alloc_ready = 1'b0;
    end else if (!w_alloc_legal) begin
      w_alloc_ready = 1'b1;
    end else begin
      w_alloc_ready = !w_sel_full && (!r_rsp_valid || bus.rsp_ready);
    end
  end

  assign bus.alloc_ready = w_alloc_ready;
  assign w_xfer          = bus.alloc_valid & w_alloc_ready &  w_alloc_legal;
  assign w_alloc_bad     = bus.alloc_valid & w_alloc_ready & ~w_alloc_legal;

  // Release tag split: type field above the index bits, upper bits ignored.
  assign w_rel_type  = TYPE_W'(bus.rel_tag >> IDX_W);
  assign w_rel_idx   = bus.rel_tag[IDX_W-1:0];
  assign w_rel_legal = (int'(w_rel_type) < NUM_TYPES);
  assign w_rel_bad   = bus.rel_valid & ~flush & ~w_rel_legal;

  for (genvar t = 0; t < NUM_TYPES; t++) begin : g_pool
    assign w_alloc_en[t] = w_xfer & (bus.alloc_type == TYPE_W'(t));
    assign w_rel_en[t]   = bus.rel_valid & ~flush & (w_rel_type == TYPE_W'(t));

    opcode_tag_pool #(
      .TAGS_PER_TYPE (TAGS_PER_TYPE),
      .IDX_W         (IDX_W),
      .CNT_W         (CNT_W)
    ) u_pool (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc_en   (w_alloc_en[t]),
      .alloc_idx  (w_alloc_idx[t]),
      .rel_en     (w_rel_en[t]),
      .rel_idx    (w_rel_idx),
      .dbl_free   (w_dbl_free[t]),
      .in_use_cnt (in_use_cnt[t*CNT_W +: CNT_W]),
      .pool_full  (pool_full[t])
    );
  end

  // One-entry response register: load on transfer, hold under
  // backpressure, drop when consumed or flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= '0;
    end else if (flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_tag   <= TAG_W'({bus.alloc_type, w_sel_idx});
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_tag   = r_rsp_tag;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_illegal     <= 1'b0;
      r_err_double_free <= 1'b0;
    end else begin
      if (w_alloc_bad || w_rel_bad) begin
        r_err_illegal <= 1'b1;
      end
      if (|w_dbl_free) begin
        r_err_double_free <= 1'b1;
      end
    end
  end

  assign err_illegal     = r_err_illegal;
  assign err_double_free = r_err_double_free;

endmodule : opcode_tag_allocator
`default_nettype wire

// File: tb/tb_opcode_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module  : tb_opcode_tag_allocator
// Brief   : Self-checking bench: directed scenarios plus random traffic,
//           compared against a set-based reference model of the pools.
// Revision: 1.0 - initial release
// ============================================================================
module tb_opcode_tag_allocator;

  localparam int NT  = 5;
  localparam int TPT = 64;
  localparam int CW  = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [NT*CW-1:0] in_use_cnt;
  logic [NT-1:0]    pool_full;
  logic             err_illegal;
  logic             err_double_free;

  opcode_tag_allocator_if #(.TYPE_W(3), .TAG_W(9)) bus ();

  opcode_tag_allocator #(
    .NUM_TYPES     (NT),
    .TAGS_PER_TYPE (TPT),
    .TAG_W         (9)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .flush           (flush),
    .in_use_cnt      (in_use_cnt),
    .pool_full       (pool_full),
    .err_illegal     (err_illegal),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which tags are out, the pending response, error flags.
  bit m_used [NT][TPT];
  bit m_rsp_valid;
  int m_rsp_tag;
  bit m_err_ill;
  bit m_err_dbl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_count(input int t);
    int c = 0;
    for (int i = 0; i < TPT; i++) c += int'(m_used[t][i]);
    return c;
  endfunction

  function automatic bit m_ready();
    int at = int'(bus.alloc_type);
    if (flush) return 1'b0;
    if (at >= NT) return 1'b1;
    if (m_count(at) == TPT) return 1'b0;
    return !m_rsp_valid || bus.rsp_ready;
  endfunction

  task automatic m_clear_pools();
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < TPT; i++) m_used[t][i] = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_step();
    int at, idx, rt, ri;
    bit acc;
    if (!rst_n) begin
      m_clear_pools();
      m_rsp_valid = 1'b0;
      m_rsp_tag   = 0;
      m_err_ill   = 1'b0;
      m_err_dbl   = 1'b0;
      return;
    end
    if (flush) begin
      m_clear_pools();
      m_rsp_valid = 1'b0;
      return;
    end
    at  = int'(bus.alloc_type);
    acc = bus.alloc_valid && m_ready();
    idx = -1;
    if (acc && at >= NT) m_err_ill = 1'b1;
    if (acc && at < NT) begin
      for (int i = 0; i < TPT; i++) begin
        if (!m_used[at][i]) begin
          idx = i;
          break;
        end
      end
    end
    if (bus.rel_valid) begin
      rt = int'(bus.rel_tag) / TPT;
      ri = int'(bus.rel_tag) % TPT;
      if (rt >= NT)              m_err_ill = 1'b1;
      else if (!m_used[rt][ri])  m_err_dbl = 1'b1;
      else                       m_used[rt][ri] = 1'b0;
    end
    if (idx >= 0) begin
      m_used[at][idx] = 1'b1;
      m_rsp_valid     = 1'b1;
      m_rsp_tag       = at * TPT + idx;
    end else if (bus.rsp_ready) begin
      m_rsp_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_val("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) check_val("rsp_tag", 32'(bus.rsp_tag), 32'(m_rsp_tag));
    for (int t = 0; t < NT; t++) begin
      check_val($sformatf("in_use_cnt[%0d]", t), 32'(in_use_cnt[t*CW +: CW]), 32'(m_count(t)));
      check_val($sformatf("pool_full[%0d]", t), 32'(pool_full[t]), 32'(m_count(t) == TPT));
    end
    check_val("err_illegal", 32'(err_illegal), 32'(m_err_ill));
    check_val("err_double_free", 32'(err_double_free), 32'(m_err_dbl));
  endtask

  // Inputs are set just after a falling edge; one tick covers one clock.
  task automatic tick();
    #1;
    if (rst_n) check_val("alloc_ready", 32'(bus.alloc_ready), 32'(m_ready()));
    m_step();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_in(input bit av, input int at, input bit rv, input int rt,
                        input bit rr, input bit fl);
    bus.alloc_valid = av;
    bus.alloc_type  = 3'(at);
    bus.rel_valid   = rv;
    bus.rel_tag     = 9'(rt);
    bus.rsp_ready   = rr;
    flush           = fl;
  endtask

  task automatic expect_tag(input string name, input int exp);
    check_val({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check_val(name, 32'(bus.rsp_tag), 32'(exp));
  endtask

  function automatic int pick_rel_tag();
    int t, s, j;
    if ($urandom_range(0, 9) < 8) begin
      t = int'($urandom_range(0, NT - 1));
      s = int'($urandom_range(0, TPT - 1));
      for (int k = 0; k < TPT; k++) begin
        j = (s + k) % TPT;
        if (m_used[t][j]) return t * TPT + j;
      end
    end
    return int'($urandom_range(0, 511));
  endfunction

  initial begin
    set_in(0, 0, 0, 0, 1, 0);
    m_clear_pools();

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    check_val("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    rst_n = 1'b1;

    // Three back-to-back allocations of type 1
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 0, 0, 1, 0);
      tick();
      expect_tag("t1_tag", 'h040 + k);
    end
    set_in(0, 0, 0, 0, 1, 0);
    tick();
    check_val("t1_cnt", 32'(in_use_cnt[CW +: CW]), 32'd3);

    // Fill type 4, then release one and get it back
    for (int k = 0; k < TPT; k++) begin
      set_in(1, 4, 0, 0, 1, 0);
      tick();
      expect_tag("t4_tag", 'h100 + k);
    end
    set_in(0, 0, 0, 0, 1, 0);
    tick();
    check_val("t4_full", 32'(pool_full[4]), 32'd1);
    set_in(1, 4, 0, 0, 1, 0);
    #1 check_val("t4_full_rdy", 32'(bus.alloc_ready), 32'd0);
    tick();
    set_in(0, 0, 1, 'h105, 1, 0);
    tick();
    set_in(1, 4, 0, 0, 1, 0);
    tick();
    expect_tag("t4_reuse", 'h105);

    // Backpressure on type 0
    set_in(1, 0, 0, 0, 1, 0);
    tick();
    expect_tag("t0_first", 'h000);
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 0, 0);
      #1 check_val("t0_hold_rdy", 32'(bus.alloc_ready), 32'd0);
      tick();
      expect_tag("t0_hold", 'h000);
    end
    set_in(1, 0, 0, 0, 1, 0);
    tick();
    expect_tag("t0_second", 'h001);

    // Full type 2: simultaneous alloc and release of 0x0A0
    for (int k = 0; k < TPT; k++) begin
      set_in(1, 2, 0, 0, 1, 0);
      tick();
    end
    set_in(1, 2, 1, 'h0A0, 1, 0);
    #1 check_val("t2_same_rdy", 32'(bus.alloc_ready), 32'd0);
    tick();
    check_val("t2_cnt", 32'(in_use_cnt[2*CW +: CW]), 32'd63);
    set_in(1, 2, 0, 0, 1, 0);
    tick();
    expect_tag("t2_reuse", 'h0A0);

    // Double free and illegal type
    set_in(0, 0, 1, 'h0C7, 1, 0);
    tick();
    check_val("dbl_flag", 32'(err_double_free), 32'd1);
    check_val("dbl_cnt3", 32'(in_use_cnt[3*CW +: CW]), 32'd0);
    set_in(1, 6, 0, 0, 1, 0);
    #1 check_val("ill_rdy", 32'(bus.alloc_ready), 32'd1);
    tick();
    check_val("ill_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check_val("ill_flag", 32'(err_illegal), 32'd1);

    // Mixed allocations then flush concurrent with an alloc
    for (int k = 0; k < 10; k++) begin
      set_in(1, k % NT, 0, 0, 1, 0);
      tick();
    end
    set_in(1, 1, 0, 0, 1, 1);
    tick();
    for (int t = 0; t < NT; t++)
      check_val("flush_cnt", 32'(in_use_cnt[t*CW +: CW]), 32'd0);
    check_val("flush_rsp", 32'(bus.rsp_valid), 32'd0);
    set_in(1, 3, 0, 0, 1, 0);
    tick();
    expect_tag("flush_t3", 'h0C0);
    check_val("flush_keep_ill", 32'(err_illegal), 32'd1);
    check_val("flush_keep_dbl", 32'(err_double_free), 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int at;
      at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 7))
                                        : int'($urandom_range(0, NT - 1));
      set_in($urandom_range(0, 3) != 0, at,
             $urandom_range(0, 2) == 0, pick_rel_tag(),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 199) == 0);
      tick();
    end

    // Reset in the middle of traffic
    set_in(1, 2, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    check_val("mid_rst_ill", 32'(err_illegal), 32'd0);
    rst_n = 1'b1;
    set_in(1, 0, 0, 0, 1, 0);
    tick();
    expect_tag("post_rst_t0", 'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_opcode_tag_allocator
`default_nettype wire
